// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch stage.
// The optional FETCH_PERF_EN build adds performance counters in fetch_unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    function automatic int entry_width(input int addr_size, input int instr_w);
        return addr_size + instr_w;
    endfunction

    // One extra bit so a full queue (count == depth) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with a single-cycle flush; flush wins over push and pop.
// Head data reads as zero whenever the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = 52,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic                          head_valid,
    output logic [WIDTH-1:0]              head_data,
    output logic [count_width(DEPTH)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer and occupancy update; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        do_pop_s  = pop & (count_q != {CNT_W{1'b0}});
        do_push_s = push & ((count_q < CNT_W'(DEPTH)) | do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != {CNT_W{1'b0}});
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : {WIDTH{1'b0}};

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding memory read per PC, results queued for decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_flushed counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_SIZE = 20,
    parameter int INSTR_W   = 32,
    parameter int FQ_DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] pc,
    input  logic                 redirect,
    output logic                 pc_stall,
    output logic                 mem_req_valid,
    output logic [ADDR_SIZE-1:0] mem_req_addr,
    input  logic                 mem_req_ready,
    input  logic                 mem_rsp_valid,
    input  logic [INSTR_W-1:0]   mem_rsp_data,
    output logic                 dec_valid,
    output logic [INSTR_W-1:0]   dec_instr,
    output logic [ADDR_SIZE-1:0] dec_pc,
    input  logic                 dec_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_flushed
`endif
);
    localparam int ENT_W = entry_width(ADDR_SIZE, INSTR_W);
    localparam int CNT_W = count_width(FQ_DEPTH);

    fetch_state_e         state_q, state_d;
    logic [ADDR_SIZE-1:0] req_pc_q, req_pc_d;
    logic                 push_s;
    logic                 flush_s;
    logic                 drop_rsp_s;
    logic [CNT_W-1:0]     count_s;
    logic [ENT_W-1:0]     head_s;

    // Next-state, request and queue-control decode.
    always_comb begin
        state_d       = state_q;
        req_pc_d      = req_pc_q;
        mem_req_valid = 1'b0;
        push_s        = 1'b0;
        flush_s       = 1'b0;
        drop_rsp_s    = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                flush_s       = redirect;
                mem_req_valid = (count_s < CNT_W'(FQ_DEPTH)) & ~redirect;
                if (mem_req_valid && mem_req_ready) begin
                    req_pc_d = pc;
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                flush_s = redirect;
                if (mem_rsp_valid) begin
                    push_s     = ~redirect;
                    drop_rsp_s = redirect;
                    state_d    = ST_IDLE;
                end else if (redirect) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DROP: begin
                flush_s = redirect;
                if (mem_rsp_valid) begin
                    drop_rsp_s = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_DROP;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
        // Redirect is not honoured while booting, so the PC is held there unconditionally.
        if (state_q == ST_BOOT) begin
            pc_stall = 1'b1;
        end else begin
            pc_stall = ~(mem_req_valid & mem_req_ready) & ~redirect;
        end
    end

    // FSM and captured request PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_BOOT;
            req_pc_q <= {ADDR_SIZE{1'b0}};
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_queue #(
        .WIDTH (ENT_W),
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush_s),
        .push       (push_s),
        .push_data  ({req_pc_q, mem_rsp_data}),
        .pop        (dec_ready),
        .head_valid (dec_valid),
        .head_data  (head_s),
        .count      (count_s)
    );

    assign mem_req_addr = pc;
    assign dec_pc       = head_s[ENT_W-1 -: ADDR_SIZE];
    assign dec_instr    = head_s[INSTR_W-1:0];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;

    // Flushed work counts queued entries at redirect plus every discarded response.
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(push_s);
        if (flush_s) begin
            perf_flushed_d = perf_flushed_q + 32'(count_s) + 32'(drop_rsp_s);
        end else begin
            perf_flushed_d = perf_flushed_q + 32'(drop_rsp_s);
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= 32'd0;
            perf_flushed_q <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a transaction-level reference model.
// Perf-counter checks are compiled in when FETCH_PERF_EN is defined.
module tb_fetch_unit;
    localparam int AW    = 20;
    localparam int IW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] pc = '0;
    logic          redirect = 1'b0;
    logic          pc_stall;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_ready = 1'b0;
    logic          mem_rsp_valid = 1'b0;
    logic [IW-1:0] mem_rsp_data = '0;
    logic          dec_valid;
    logic [IW-1:0] dec_instr;
    logic [AW-1:0] dec_pc;
    logic          dec_ready = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_flushed;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_SIZE(AW), .INSTR_W(IW), .FQ_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .redirect      (redirect),
        .pc_stall      (pc_stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .dec_valid     (dec_valid),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .dec_ready     (dec_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_flushed  (perf_flushed)
`endif
    );

    typedef struct {
        logic [AW-1:0] epc;
        logic [IW-1:0] instr;
    } ent_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queued entries and the single outstanding read.
    ent_t          mq[$];
    bit            m_boot;
    bit            m_out;
    bit            m_drop;
    logic [AW-1:0] m_req_pc;
    logic [31:0]   m_fetched;
    logic [31:0]   m_flushed;

    // Environment: PC-update stage and memory.
    logic [AW-1:0] pc_r = '0;
    bit            mem_pend;
    int            mem_cnt;
    logic [IW-1:0] mem_dat;

    int rdy_pct, pop_pct, redir_pct, stray_pct, lat_max;
    bit data_fixed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_boot    = 1'b1;
        m_out     = 1'b0;
        m_drop    = 1'b0;
        m_req_pc  = '0;
        m_fetched = 32'd0;
        m_flushed = 32'd0;
        mem_pend  = 1'b0;
        mem_cnt   = 0;
    endtask

    task automatic step();
        logic [AW-1:0] tgt;
        bit            exp_valid, exp_hs, exp_stall, dut_hs, dut_stall, do_push;
        ent_t          e;

        tgt           = AW'($urandom) & 20'hFFFFC;
        redirect      = !reset && ($urandom_range(99) < redir_pct);
        pc            = pc_r;
        mem_req_ready = ($urandom_range(99) < rdy_pct);
        dec_ready     = ($urandom_range(99) < pop_pct);
        mem_rsp_data  = $urandom;
        if (mem_pend && mem_cnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_dat;
        end else if (!mem_pend && !m_out && ($urandom_range(99) < stray_pct)) begin
            mem_rsp_valid = 1'b1;
        end else begin
            mem_rsp_valid = 1'b0;
        end

        #4;
        exp_valid = !m_boot && !m_out && (mq.size() < DEPTH) && !redirect;
        exp_hs    = exp_valid && mem_req_ready;
        exp_stall = m_boot ? 1'b1 : (!exp_hs && !redirect);
        e.epc     = '0;
        e.instr   = '0;
        if (mq.size() > 0) e = mq[0];
        chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_valid));
        chk("mem_req_addr", 32'(mem_req_addr), 32'(pc_r));
        chk("pc_stall", 32'(pc_stall), 32'(exp_stall));
        chk("dec_valid", 32'(dec_valid), 32'(mq.size() > 0));
        chk("dec_pc", 32'(dec_pc), 32'(e.epc));
        chk("dec_instr", dec_instr, e.instr);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_flushed", perf_flushed, m_flushed);
`endif
        dut_hs    = mem_req_valid && mem_req_ready;
        dut_stall = pc_stall;

        if (reset) begin
            m_boot = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            do_push = 1'b0;
            if (mem_rsp_valid && m_out) begin
                if (m_drop || redirect) m_flushed++;
                else do_push = 1'b1;
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            if (redirect) begin
                m_flushed += 32'(mq.size());
                mq.delete();
                if (m_out) m_drop = 1'b1;
            end else begin
                if (dec_ready && mq.size() > 0) void'(mq.pop_front());
                if (do_push) begin
                    e.epc   = m_req_pc;
                    e.instr = mem_rsp_data;
                    mq.push_back(e);
                    m_fetched++;
                end
            end
            if (exp_hs) begin
                m_out    = 1'b1;
                m_drop   = 1'b0;
                m_req_pc = pc_r;
            end
        end

        if (mem_pend && mem_cnt == 0) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (!reset && dut_hs) begin
            mem_pend = 1'b1;
            mem_cnt  = $urandom_range(lat_max, 1) - 1;
            mem_dat  = data_fixed ? (32'h13 ^ 32'(pc_r)) : $urandom;
        end
        if (redirect) pc_r = tgt;
        else if (!dut_stall) pc_r = pc_r + AW'(4);

        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rdy_pct = 100; pop_pct = 0; redir_pct = 0; stray_pct = 0; lat_max = 1; data_fixed = 1'b1;
        model_reset();
        run(2);
        reset = 1'b0;
        run(12);

        // Drain, then hold memory off so the request waits with PC held.
        pop_pct = 100;
        run(4);
        rdy_pct = 0;
        run(5);
        rdy_pct = 100;
        run(6);

        // Mixed random traffic with redirects, slow memory and stray responses.
        data_fixed = 1'b0; rdy_pct = 70; pop_pct = 50; redir_pct = 10; stray_pct = 5; lat_max = 4;
        run(1500);

        // Asynchronous reset in the middle of traffic.
        reset = 1'b1;
        model_reset();
        run(2);
        reset = 1'b0;
        redir_pct = 25; pop_pct = 30; stray_pct = 10;
        run(500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC-update stage.
- Consumes the current PC and issues one instruction-memory read per PC value, with at most one request outstanding.
- Buffers returned instructions, tagged with their PC, in a small queue for the decoder.
- Drives the PC-update stage's stall input so the PC advances only when a fetch request is accepted or a redirect occurs; flushes in-flight and queued work on redirect.

Parameters:
- ADDR_SIZE, 20, PC / memory address width.
- INSTR_W, 32, instruction word width.
- FQ_DEPTH, 2, fetch-queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pc  in  ADDR_SIZE  current PC from PC-update stage
- redirect  in  1  PC-update stage loads a jump target this cycle (its select input is nonzero)
- pc_stall  out  1  to PC-update stage stall input; 1 = hold PC
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  ADDR_SIZE  fetch address (= pc)
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  read data valid (one pulse per accepted request, latency ≥1 cycle)
- mem_rsp_data  in  INSTR_W  read data
- dec_valid  out  1  queue head valid
- dec_instr  out  INSTR_W  queue head instruction
- dec_pc  out  ADDR_SIZE  queue head PC
- dec_ready  in  1  decoder pops head

Behaviour:
- FSM states: BOOT, IDLE, WAIT, DROP. Async reset → BOOT, queue empty, req_pc=0.
- Reset values: mem_req_valid=0, pc_stall=1, dec_valid=0, dec_instr=0, dec_pc=0, mem_req_addr=pc.
- BOOT: lasts exactly one cycle, then IDLE. No request is issued; pc_stall=1.
- IDLE:
  - mem_req_valid = (count < FQ_DEPTH) & ~redirect.
  - On handshake (valid & ready): latch req_pc=pc, go to WAIT.
- WAIT:
  - On mem_rsp_valid: push {req_pc, mem_rsp_data}, go to IDLE.
  - No new request is issued in WAIT.
- DROP: next mem_rsp_valid is discarded, then go to IDLE.
- pc_stall = ~(mem_req_valid & mem_req_ready) & ~redirect. The PC advances exactly once per accepted request, or once on redirect.
- Redirect, any state except BOOT:
  - Queue is flushed in the same cycle (count=0 next cycle).
  - Any pop in that cycle is ignored.
  - IDLE: no request is issued.
  - WAIT without rsp that cycle: go to DROP.
  - WAIT with rsp that cycle: response is discarded, go to IDLE.
  - DROP: stays DROP, or goes to IDLE if rsp arrives that cycle.
- Redirect during BOOT is ignored.
- Queue rules:
  - Push and pop in the same cycle are legal.
  - Pop when empty is ignored.
  - Push never occurs when full: an issue requires count < FQ_DEPTH, and count cannot rise during WAIT.
  - Pointers wrap modulo FQ_DEPTH; count is $clog2(FQ_DEPTH)+1 bits.
- dec_* are driven combinationally from the queue head. dec_instr and dec_pc are 0 when empty.
- Earliest latency: PC presented in IDLE → dec_valid 2 cycles later with 1-cycle memory (request accepted in cycle N, rsp in N+1, dec_valid in N+2).
- Reset asserted mid-transaction: all state is cleared immediately. A late memory response arriving while in BOOT or IDLE is ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_flushed[31:0], both reset to 0 and wrapping at 2^32.
  - perf_fetched increments on each queue push.
  - perf_flushed increments by the number of entries discarded: queue count at redirect, plus 1 for each dropped response.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- fetch_pkg holds:
  - state encoding localparams (BOOT/IDLE/WAIT/DROP);
  - the queue entry width function (ADDR_SIZE+INSTR_W);
  - the count-width helper.
- One sub-module: fetch_queue, a synchronous FIFO with a flush input, parameterised on width and depth, with async reset.

Test Plan:
- Reset release, pc=0, mem_req_ready=1, 1-cycle rsp data 0x00000013 → BOOT 1 cycle, then req addr 0x00000 accepted and pc_stall=0 for one cycle; dec_valid with dec_pc=0, dec_instr=0x13 two cycles after the request.
- dec_ready=0, continuous fetch → queue fills to 2; mem_req_valid=0 and pc_stall=1 hold until a pop, then one new request is issued.
- mem_req_ready=0 for 5 cycles at pc=0x10 → mem_req_valid=1 and pc_stall=1 throughout, PC held, request accepted on cycle 6.
- redirect in WAIT (rsp delayed 3 cycles) → next rsp discarded, queue empty, next request uses new pc=0x200; dec_pc=0x200.
- redirect in the same cycle as mem_rsp_valid and a dec pop with 1 entry queued → no push, queue count 0, FSM IDLE, pc_stall=0 that cycle.
- FETCH_PERF_EN: 3 fetches, then a redirect with 2 queued plus 1 in flight → perf_fetched=3, perf_flushed=3.
